// File: rtl/bc_msg_bcast.sv
// ---------------------------------------------------------------------------
// bc_msg_bcast
// Broadcast-message hub shared by the per-core PR wrappers. Each core hands
// its outgoing broadcast message to a one-entry holding register. A
// round-robin arbiter picks one held message per cycle and re-broadcasts it
// to every core through a registered, valid-only output port. The hub also
// discards held messages of flushed cores, and it keeps wrapping counters of
// broadcast and discarded messages for the status path.
//
// Ports:
//   clk          - single clock for all logic
//   rst_n        - asynchronous active-low reset
//   s_msg_data   - per-core outgoing message, core i at [i*MSG_WIDTH +: MSG_WIDTH]
//   s_msg_valid  - per-core message valid
//   s_msg_ready  - per-core ready (holding slot free, or being drained now)
//   core_flush   - per-core level-sensitive flush
//   m_msg_data   - broadcast message fanned out to all cores
//   m_msg_valid  - broadcast valid, one-cycle pulse per message
//   m_msg_src    - index of the core that sourced m_msg_data
//   bc_count     - wrapping count of broadcast messages
//   drop_count   - wrapping count of messages discarded by flush
// ---------------------------------------------------------------------------
module bc_msg_bcast #(
  parameter int CORE_COUNT    = 8,
  parameter int CORE_ID_WIDTH = 3,
  parameter int MSG_WIDTH     = 47,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0]  s_msg_data,
  input  logic [CORE_COUNT-1:0]            s_msg_valid,
  output logic [CORE_COUNT-1:0]            s_msg_ready,
  input  logic [CORE_COUNT-1:0]            core_flush,
  output logic [MSG_WIDTH-1:0]             m_msg_data,
  output logic                             m_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]         m_msg_src,
  output logic [CNT_WIDTH-1:0]             bc_count,
  output logic [CNT_WIDTH-1:0]             drop_count
);

  logic [MSG_WIDTH-1:0]     r_holdData [CORE_COUNT];
  logic [CORE_COUNT-1:0]    r_holdValid;
  logic [CORE_ID_WIDTH-1:0] r_rrPtr;

  logic [MSG_WIDTH-1:0]     r_msgData;
  logic                     r_msgValid;
  logic [CORE_ID_WIDTH-1:0] r_msgSrc;
  logic [CNT_WIDTH-1:0]     r_bcCount;
  logic [CNT_WIDTH-1:0]     r_dropCount;

  logic [CORE_COUNT-1:0]    w_req;
  logic [CORE_COUNT-1:0]    w_grant;
  logic [CORE_COUNT-1:0]    w_accept;
  logic [CORE_COUNT-1:0]    w_drop;
  logic [CORE_ID_WIDTH-1:0] w_grantIdx;
  logic [CORE_ID_WIDTH-1:0] w_arbIdx;
  logic                     w_anyGrant;
  logic [CORE_ID_WIDTH-1:0] w_rrNext;
  logic [CNT_WIDTH-1:0]     w_dropInc;

  // A flushed core neither competes for the broadcast slot nor accepts new
  // messages. A held message that meets a flush is counted as dropped. The
  // slot is cleared on every flush cycle, so only the first flush cycle can
  // ever see a valid entry.
  assign w_req       = r_holdValid & ~core_flush;
  assign w_drop      = r_holdValid & core_flush;
  assign s_msg_ready = ~core_flush & (~r_holdValid | w_grant);
  assign w_accept    = s_msg_valid & s_msg_ready;

  // Round-robin search: walk upward from the pointer, wrapping, and take the
  // first requesting core. The pointer then moves just past the winner.
  always_comb begin
    w_grant    = '0;
    w_grantIdx = '0;
    w_anyGrant = 1'b0;
    w_arbIdx   = '0;
    for (int off = 0; off < CORE_COUNT; off++) begin
      w_arbIdx = CORE_ID_WIDTH'((int'(r_rrPtr) + off) % CORE_COUNT);
      if (!w_anyGrant && w_req[w_arbIdx]) begin
        w_anyGrant         = 1'b1;
        w_grant[w_arbIdx]  = 1'b1;
        w_grantIdx         = w_arbIdx;
      end
    end
  end

  assign w_rrNext = CORE_ID_WIDTH'((int'(w_grantIdx) + 1) % CORE_COUNT);

  // Several cores can be flushed in the same cycle, so the drop counter
  // advances by the number of slots discarded together.
  always_comb begin
    w_dropInc = '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      w_dropInc = w_dropInc + CNT_WIDTH'(w_drop[i]);
    end
  end

  // Holding slots. A flush has priority and empties the slot. An accept
  // refills it, even when the old entry is granted in the same cycle, so a
  // lone requester can stream one message per cycle. A grant with no accept
  // empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_holdValid <= '0;
      for (int i = 0; i < CORE_COUNT; i++) begin
        r_holdData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CORE_COUNT; i++) begin
        if (core_flush[i]) begin
          r_holdValid[i] <= 1'b0;
        end else if (w_accept[i]) begin
          r_holdValid[i] <= 1'b1;
          r_holdData[i]  <= s_msg_data[i*MSG_WIDTH +: MSG_WIDTH];
        end else if (w_grant[i]) begin
          r_holdValid[i] <= 1'b0;
        end
      end
    end
  end

  // Arbitration pointer. It holds when nobody requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (w_anyGrant) begin
      r_rrPtr <= w_rrNext;
    end
  end

  // Broadcast register and counters. Valid is refreshed every cycle. Data
  // and source only move on a grant, so consumers must qualify them with
  // valid. bc_count steps on the same edge that raises valid, so it already
  // includes the message on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msgValid  <= 1'b0;
      r_msgData   <= '0;
      r_msgSrc    <= '0;
      r_bcCount   <= '0;
      r_dropCount <= '0;
    end else begin
      r_msgValid  <= w_anyGrant;
      if (w_anyGrant) begin
        r_msgData <= r_holdData[w_grantIdx];
        r_msgSrc  <= w_grantIdx;
        r_bcCount <= r_bcCount + CNT_WIDTH'(1);
      end
      r_dropCount <= r_dropCount + w_dropInc;
    end
  end

  assign m_msg_valid = r_msgValid;
  assign m_msg_data  = r_msgData;
  assign m_msg_src   = r_msgSrc;
  assign bc_count    = r_bcCount;
  assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_bc_msg_bcast.sv
// ---------------------------------------------------------------------------
// tb_bc_msg_bcast
// Directed bench for the broadcast hub. Inputs change 1 ns after the rising
// edge. Outputs are sampled at that same point, once the registers have
// settled. Every expected value below is worked out by hand from the
// arbitration and latency rules.
// ---------------------------------------------------------------------------
module tb_bc_msg_bcast;

  localparam int CORE_COUNT    = 8;
  localparam int CORE_ID_WIDTH = 3;
  localparam int MSG_WIDTH     = 47;
  localparam int CNT_WIDTH     = 32;

  logic                            clk;
  logic                            rst_n;
  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg_data;
  logic [CORE_COUNT-1:0]           s_msg_valid;
  logic [CORE_COUNT-1:0]           s_msg_ready;
  logic [CORE_COUNT-1:0]           core_flush;
  logic [MSG_WIDTH-1:0]            m_msg_data;
  logic                            m_msg_valid;
  logic [CORE_ID_WIDTH-1:0]        m_msg_src;
  logic [CNT_WIDTH-1:0]            bc_count;
  logic [CNT_WIDTH-1:0]            drop_count;

  int total;
  int bad;
  int srcCount [CORE_COUNT];

  bc_msg_bcast #(
    .CORE_COUNT   (CORE_COUNT),
    .CORE_ID_WIDTH(CORE_ID_WIDTH),
    .MSG_WIDTH    (MSG_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_msg_data (s_msg_data),
    .s_msg_valid(s_msg_valid),
    .s_msg_ready(s_msg_ready),
    .core_flush (core_flush),
    .m_msg_data (m_msg_data),
    .m_msg_valid(m_msg_valid),
    .m_msg_src  (m_msg_src),
    .bc_count   (bc_count),
    .drop_count (drop_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setCoreData(input int core, input logic [MSG_WIDTH-1:0] value);
    s_msg_data[core*MSG_WIDTH +: MSG_WIDTH] = value;
  endtask

  task automatic applyStimulus(input logic [CORE_COUNT-1:0] valid,
                               input logic [CORE_COUNT-1:0] flush);
    s_msg_valid = valid;
    core_flush  = flush;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(8'h00, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Single directed sequence covering reset, arbitration, streaming,
  // fairness, flush and asynchronous reset.
  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < CORE_COUNT; i++) srcCount[i] = 0;
    rst_n      = 1'b0;
    s_msg_data = '0;
    applyStimulus(8'h00, 8'h00);
    tick();
    tick();

    // Reset state
    checkOutput("rst_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("rst_data",  64'(m_msg_data),  64'd0);
    checkOutput("rst_src",   64'(m_msg_src),   64'd0);
    checkOutput("rst_bc",    64'(bc_count),    64'd0);
    checkOutput("rst_drop",  64'(drop_count),  64'd0);
    checkOutput("rst_ready", 64'(s_msg_ready), 64'hFF);
    applyStimulus(8'h00, 8'h10);
    #1;
    checkOutput("rst_ready_flush", 64'(s_msg_ready), 64'hEF);
    applyStimulus(8'h00, 8'h00);
    rst_n = 1'b1;
    tick();

    // Round robin: cores 0, 3 and 7 load in the same cycle
    setCoreData(0, 47'h0A0);
    setCoreData(3, 47'h0A3);
    setCoreData(7, 47'h0A7);
    applyStimulus(8'h89, 8'h00);
    tick();
    applyStimulus(8'h00, 8'h00);
    checkOutput("rr_pre_valid", 64'(m_msg_valid), 64'd0);
    tick();
    checkOutput("rr0_valid", 64'(m_msg_valid), 64'd1);
    checkOutput("rr0_src",   64'(m_msg_src),   64'd0);
    checkOutput("rr0_data",  64'(m_msg_data),  64'h0A0);
    tick();
    checkOutput("rr1_valid", 64'(m_msg_valid), 64'd1);
    checkOutput("rr1_src",   64'(m_msg_src),   64'd3);
    checkOutput("rr1_data",  64'(m_msg_data),  64'h0A3);
    tick();
    checkOutput("rr2_valid", 64'(m_msg_valid), 64'd1);
    checkOutput("rr2_src",   64'(m_msg_src),   64'd7);
    checkOutput("rr2_data",  64'(m_msg_data),  64'h0A7);
    tick();
    checkOutput("rr_end_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("rr_end_bc",    64'(bc_count),    64'd3);

    // Pointer wrapped to 0 after core 7, so core 0 must beat core 1
    setCoreData(0, 47'h0B0);
    setCoreData(1, 47'h0B1);
    applyStimulus(8'h03, 8'h00);
    tick();
    applyStimulus(8'h00, 8'h00);
    tick();
    checkOutput("ptr_first_src",  64'(m_msg_src),  64'd0);
    checkOutput("ptr_first_data", 64'(m_msg_data), 64'h0B0);
    tick();
    checkOutput("ptr_second_src",  64'(m_msg_src),  64'd1);
    checkOutput("ptr_second_data", 64'(m_msg_data), 64'h0B1);
    tick();
    checkOutput("ptr_end_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("ptr_end_bc",    64'(bc_count),    64'd5);

    // Single core with T+2 latency
    doReset();
    setCoreData(2, 47'h1234);
    applyStimulus(8'h04, 8'h00);
    tick();
    applyStimulus(8'h00, 8'h00);
    checkOutput("single_t1_valid", 64'(m_msg_valid), 64'd0);
    tick();
    checkOutput("single_valid", 64'(m_msg_valid), 64'd1);
    checkOutput("single_data",  64'(m_msg_data),  64'h1234);
    checkOutput("single_src",   64'(m_msg_src),   64'd2);
    checkOutput("single_bc",    64'(bc_count),    64'd1);
    tick();
    checkOutput("single_after_valid", 64'(m_msg_valid), 64'd0);

    // Streaming: core 5 alone, 16 back-to-back messages
    doReset();
    setCoreData(5, 47'h500);
    applyStimulus(8'h20, 8'h00);
    #1;
    checkOutput("stream_ready0", 64'(s_msg_ready[5]), 64'd1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k < 16) setCoreData(5, 47'(k + 'h500));
      else applyStimulus(8'h00, 8'h00);
      if (k >= 2) begin
        checkOutput("stream_valid", 64'(m_msg_valid), 64'd1);
        checkOutput("stream_data",  64'(m_msg_data),  64'(k - 2 + 'h500));
      end
      if (k < 16) begin
        #1;
        checkOutput("stream_ready", 64'(s_msg_ready[5]), 64'd1);
      end
    end
    tick();
    checkOutput("stream_end_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("stream_bc",        64'(bc_count),    64'd16);

    // Contention: all cores request continuously for 64 cycles
    doReset();
    for (int i = 0; i < CORE_COUNT; i++) setCoreData(i, 47'(i + 'h7000));
    applyStimulus(8'hFF, 8'h00);
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 64) applyStimulus(8'h00, 8'h00);
      if (k >= 2) begin
        checkOutput("fair_valid", 64'(m_msg_valid), 64'd1);
        checkOutput("fair_src",   64'(m_msg_src),   64'((k - 2) % 8));
        checkOutput("fair_data",  64'(m_msg_data),  64'(((k - 2) % 8) + 'h7000));
        if (!$isunknown(m_msg_src)) srcCount[m_msg_src]++;
      end
    end
    for (int i = 0; i < CORE_COUNT; i++) begin
      checkOutput($sformatf("fair_count%0d", i), 64'(srcCount[i]), 64'd8);
    end
    repeat (10) tick();
    checkOutput("fair_drain_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("fair_drain_bc",    64'(bc_count),    64'd71);

    // Flush: core 1 holds a message, then is flushed for 3 cycles
    doReset();
    setCoreData(1, 47'h1111);
    applyStimulus(8'h02, 8'h00);
    tick();
    setCoreData(1, 47'hBAD);
    applyStimulus(8'h02, 8'h02);
    #1;
    checkOutput("flush_ready_c1", 64'(s_msg_ready[1]), 64'd0);
    tick();
    checkOutput("flush_valid_c2", 64'(m_msg_valid), 64'd0);
    checkOutput("flush_drop_c2",  64'(drop_count),  64'd1);
    #1;
    checkOutput("flush_ready_c2", 64'(s_msg_ready[1]), 64'd0);
    tick();
    checkOutput("flush_valid_c3", 64'(m_msg_valid), 64'd0);
    checkOutput("flush_drop_c3",  64'(drop_count),  64'd1);
    #1;
    checkOutput("flush_ready_c3", 64'(s_msg_ready[1]), 64'd0);
    tick();
    applyStimulus(8'h00, 8'h00);
    checkOutput("flush_valid_c4", 64'(m_msg_valid), 64'd0);
    checkOutput("flush_drop_c4",  64'(drop_count),  64'd1);
    tick();
    checkOutput("flush_no_bad_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("flush_ready_after",  64'(s_msg_ready[1]), 64'd1);
    setCoreData(1, 47'h2222);
    applyStimulus(8'h02, 8'h00);
    tick();
    applyStimulus(8'h00, 8'h00);
    tick();
    checkOutput("flush_new_valid", 64'(m_msg_valid), 64'd1);
    checkOutput("flush_new_src",   64'(m_msg_src),   64'd1);
    checkOutput("flush_new_data",  64'(m_msg_data),  64'h2222);
    checkOutput("flush_new_bc",    64'(bc_count),    64'd1);
    checkOutput("flush_new_drop",  64'(drop_count),  64'd1);

    // Two cores flushed together add two drops
    setCoreData(0, 47'h3330);
    setCoreData(3, 47'h3333);
    applyStimulus(8'h09, 8'h00);
    tick();
    applyStimulus(8'h00, 8'h09);
    tick();
    checkOutput("multi_drop_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("multi_drop_count", 64'(drop_count),  64'd3);
    applyStimulus(8'h00, 8'h00);
    tick();
    checkOutput("multi_drop_after_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("multi_drop_after_bc",    64'(bc_count),    64'd1);

    // Asynchronous reset in the middle of a stream from core 4
    setCoreData(4, 47'h4444);
    applyStimulus(8'h10, 8'h00);
    tick();
    tick();
    checkOutput("async_pre_valid", 64'(m_msg_valid), 64'd1);
    checkOutput("async_pre_src",   64'(m_msg_src),   64'd4);
    checkOutput("async_pre_bc",    64'(bc_count),    64'd2);
    #2;
    rst_n = 1'b0;
    applyStimulus(8'h00, 8'h00);
    #1;
    checkOutput("async_valid", 64'(m_msg_valid), 64'd0);
    checkOutput("async_bc",    64'(bc_count),    64'd0);
    checkOutput("async_drop",  64'(drop_count),  64'd0);
    checkOutput("async_data",  64'(m_msg_data),  64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("async_lost_valid1", 64'(m_msg_valid), 64'd0);
    tick();
    checkOutput("async_lost_valid2", 64'(m_msg_valid), 64'd0);
    setCoreData(6, 47'h6666);
    applyStimulus(8'h40, 8'h00);
    tick();
    applyStimulus(8'h00, 8'h00);
    checkOutput("async_t1_valid", 64'(m_msg_valid), 64'd0);
    tick();
    checkOutput("async_t2_valid", 64'(m_msg_valid), 64'd1);
    checkOutput("async_t2_data",  64'(m_msg_data),  64'h6666);
    checkOutput("async_t2_src",   64'(m_msg_src),   64'd6);
    checkOutput("async_t2_bc",    64'(bc_count),    64'd1);
    checkOutput("async_t2_drop",  64'(drop_count),  64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
